// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM states, cause codes,
// and the priority helper used to pick the winning interrupt source.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    HOLDOFF = 2'd2
  } trap_state_t;

  localparam logic [2:0] CAUSE_ILLEGAL  = 3'd0;
  localparam logic [2:0] CAUSE_IRQ_BASE = 3'd4;
  localparam int         MAX_SRC        = 4;

  // Index of the lowest set bit; source 0 has the highest priority.
  function automatic logic [1:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Per-source rising-edge detector with a sticky pending bit; a new edge wins
// over a simultaneous clear so no request is ever lost.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pending
);

  logic irq_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= irq;
      pending  <= (irq & ~irq_prev) | (pending & ~clr);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Interrupt/exception sequencer: edge-latched requests, software mask,
// fixed-priority select and the IDLE/SERVICE/HOLDOFF trap FSM.
module trap_controller
  import trap_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               pchigh,
  input  logic               illegal_op,
  input  logic               eret,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               Interrupt,
  output logic               Exception,
  output logic [2:0]         cause,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               in_service
);

  trap_state_t          state;
  logic [NUM_SRC-1:0]   elig;
  logic [MAX_SRC-1:0]   elig_ext;
  logic [1:0]           sel;
  logic [NUM_SRC-1:0]   clr;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig                   = pending & mask;
    elig_ext               = '0;
    elig_ext[NUM_SRC-1:0]  = elig;
    sel                    = lowest_set(elig_ext);
  end

  assign Exception = illegal_op & ~pchigh & (state != SERVICE) & ~reset;
  assign Interrupt = (state == IDLE) & ~pchigh & (|elig) & ~illegal_op & ~reset;

  // Only the source actually taken is cleared; blocked requests stay pending.
  assign clr = Interrupt ? (NUM_SRC'(1) << sel) : '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_latch u_latch (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq_src[g]),
      .clr     (clr[g]),
      .pending (pending[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      cause      <= CAUSE_ILLEGAL;
      in_service <= 1'b0;
    end else begin
      if (mask_wr) mask <= mask_wdata;
      case (state)
        IDLE: begin
          if (Exception) begin
            state      <= SERVICE;
            cause      <= CAUSE_ILLEGAL;
            in_service <= 1'b1;
          end else if (Interrupt) begin
            state      <= SERVICE;
            cause      <= CAUSE_IRQ_BASE + {1'b0, sel};
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (eret) begin
            state      <= HOLDOFF;
            in_service <= 1'b0;
          end
        end
        HOLDOFF: begin
          // One-cycle gap so the instruction at the return address retires
          // before another interrupt; exceptions may still re-enter at once.
          if (Exception) begin
            state      <= SERVICE;
            cause      <= CAUSE_ILLEGAL;
            in_service <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_trap_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       pchigh, illegal_op, eret, mask_wr;
  logic [3:0] mask_wdata;
  logic       Interrupt, Exception, in_service;
  logic [2:0] cause;
  logic [3:0] pending, mask;

  int n_vec  = 0;
  int n_miss = 0;

  trap_controller #(.NUM_SRC(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .pchigh     (pchigh),
    .illegal_op (illegal_op),
    .eret       (eret),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .Interrupt  (Interrupt),
    .Exception  (Exception),
    .cause      (cause),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = idle, 1 = servicing a trap, 2 = post-return gap.
  bit [3:0] m_pend, m_prev, m_mask;
  bit [2:0] m_cause;
  int       m_mode;

  task automatic model_comb(output bit ei, output bit ee, output int s);
    s = -1;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && m_mask[i] && s < 0) s = i;
    ee = illegal_op && !pchigh && (m_mode != 1) && !reset;
    ei = (m_mode == 0) && !pchigh && (s >= 0) && !illegal_op && !reset;
  endtask

  task automatic model_tick();
    bit ei, ee;
    int s;
    bit [3:0] edges;
    model_comb(ei, ee, s);
    if (reset) begin
      m_pend = '0; m_prev = '0; m_mask = '0; m_cause = '0; m_mode = 0;
    end else begin
      edges  = irq_src & ~m_prev;
      m_prev = irq_src;
      if (ei) m_pend[s] = 1'b0;
      m_pend = m_pend | edges;
      if (mask_wr) m_mask = mask_wdata;
      case (m_mode)
        0: if (ee) begin m_mode = 1; m_cause = 3'd0; end
           else if (ei) begin m_mode = 1; m_cause = 3'(4 + s); end
        1: if (eret) m_mode = 2;
        default: if (ee) begin m_mode = 1; m_cause = 3'd0; end
                 else m_mode = 0;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input bit ei, input bit ee, input bit [2:0] ec,
                            input bit [3:0] ep, input bit [3:0] em, input bit es);
    check({name, ".Interrupt"},  8'(Interrupt),  8'(ei));
    check({name, ".Exception"},  8'(Exception),  8'(ee));
    check({name, ".cause"},      8'(cause),      8'(ec));
    check({name, ".pending"},    8'(pending),    8'(ep));
    check({name, ".mask"},       8'(mask),       8'(em));
    check({name, ".in_service"}, 8'(in_service), 8'(es));
  endtask

  task automatic drive(input bit r, input bit [3:0] irq, input bit pc, input bit ill,
                       input bit er, input bit mw, input bit [3:0] md);
    reset = r; irq_src = irq; pchigh = pc; illegal_op = ill;
    eret = er; mask_wr = mw; mask_wdata = md;
    #1;
  endtask

  // Advance through one rising edge, keeping the model in lockstep.
  task automatic cycle_end();
    model_tick();
    @(negedge clk);
  endtask

  typedef struct {
    bit rst; bit [3:0] irq; bit pch, ill, er, mw; bit [3:0] md;
    bit ei, ee; bit [2:0] ec; bit [3:0] ep, em; bit es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit [3:0] irq, bit pch, bit ill, bit er, bit mw, bit [3:0] md,
                             bit ei, bit ee, bit [2:0] ec, bit [3:0] ep, bit [3:0] em, bit es);
    vec_t t;
    t.rst = rst; t.irq = irq; t.pch = pch; t.ill = ill; t.er = er; t.mw = mw; t.md = md;
    t.ei = ei; t.ee = ee; t.ec = ec; t.ep = ep; t.em = em; t.es = es;
    return t;
  endfunction

  initial begin
    //                 rst irq     pch ill er mw md       ei ee ec ep       em       es
    tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v(0, 4'b0000, 0, 0, 0, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0100, 4'b1111, 0));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, 6, 4'b0000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b0100, 0, 0, 1, 0, 4'b0000, 0, 0, 6, 4'b0000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, 6, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, 6, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 6, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 1, 0, 6, 4'b1010, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 5, 4'b1000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1010, 0, 0, 1, 0, 4'b0000, 0, 0, 5, 4'b1000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 5, 4'b1000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 1, 0, 5, 4'b1000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 7, 4'b0000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1010, 0, 0, 1, 0, 4'b0000, 0, 0, 7, 4'b0000, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 7, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1010, 0, 0, 0, 0, 4'b0000, 0, 0, 7, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 0, 0, 7, 4'b0000, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1011, 0, 1, 0, 0, 4'b0000, 0, 1, 7, 4'b0001, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1011, 0, 1, 1, 0, 4'b0000, 0, 0, 0, 4'b0001, 4'b1111, 1));
    tbl.push_back(v(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b1111, 0));
    tbl.push_back(v(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 0, 0, 4, 4'b0000, 4'b1111, 1));

    // Two unchecked reset cycles so registered outputs leave their unknown state.
    drive(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
    @(negedge clk); cycle_end();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].pch, tbl[i].ill, tbl[i].er, tbl[i].mw, tbl[i].md);
      check_outs($sformatf("tbl[%0d]", i), tbl[i].ei, tbl[i].ee, tbl[i].ec,
                 tbl[i].ep, tbl[i].em, tbl[i].es);
      cycle_end();
    end

    // Masked source still latches; unmasking raises Interrupt the next cycle.
    drive(1, 4'b0000, 0, 1, 0, 0, 4'b0000);
    check("mask.rst.Exception", 8'(Exception), 8'd0);
    check("mask.rst.Interrupt", 8'(Interrupt), 8'd0);
    cycle_end();
    drive(0, 4'b0001, 0, 0, 0, 0, 4'b0000);
    check_outs("mask.c1", 0, 0, 0, 4'b0000, 4'b0000, 0); cycle_end();
    drive(0, 4'b0001, 0, 0, 0, 1, 4'b0001);
    check_outs("mask.c2", 0, 0, 0, 4'b0001, 4'b0000, 0); cycle_end();
    drive(0, 4'b0001, 0, 0, 0, 0, 4'b0000);
    check_outs("mask.c3", 1, 0, 0, 4'b0001, 4'b0001, 0); cycle_end();
    check_outs("mask.c4", 0, 0, 4, 4'b0000, 4'b0001, 1);

    // Kernel mode blocks both trap kinds; dropping pchigh fires the exception at once.
    drive(1, 4'b0000, 0, 0, 0, 0, 4'b0000); cycle_end();
    drive(0, 4'b0000, 0, 0, 0, 1, 4'b1111); cycle_end();
    drive(0, 4'b0010, 1, 0, 0, 0, 4'b0000); cycle_end();
    drive(0, 4'b0010, 1, 1, 0, 0, 4'b0000);
    check_outs("pch.high", 0, 0, 0, 4'b0010, 4'b1111, 0); cycle_end();
    drive(0, 4'b0010, 0, 1, 0, 0, 4'b0000);
    check_outs("pch.drop", 0, 1, 0, 4'b0010, 4'b1111, 0); cycle_end();
    drive(0, 4'b0010, 0, 0, 0, 0, 4'b0000);
    check_outs("pch.svc", 0, 0, 0, 4'b0010, 4'b1111, 1); cycle_end();

    // Reset while servicing: everything clears and a following eret is ignored.
    drive(0, 4'b1010, 0, 0, 0, 0, 4'b0000); cycle_end();
    drive(0, 4'b1010, 0, 0, 0, 0, 4'b0000);
    check_outs("rsv.pend", 0, 0, 0, 4'b1010, 4'b1111, 1); cycle_end();
    drive(1, 4'b1010, 0, 0, 0, 0, 4'b0000);
    check("rsv.rst.Interrupt", 8'(Interrupt), 8'd0);
    check("rsv.rst.Exception", 8'(Exception), 8'd0);
    cycle_end();
    drive(0, 4'b1010, 0, 0, 1, 1, 4'b1111);
    check_outs("rsv.after", 0, 0, 0, 4'b0000, 4'b0000, 0); cycle_end();
    drive(0, 4'b1010, 0, 0, 0, 0, 4'b0000);
    check_outs("rsv.idle", 1, 0, 0, 4'b1010, 4'b1111, 0); cycle_end();
    check_outs("rsv.svc", 0, 0, 5, 4'b1000, 4'b1111, 1);

    // Random phase against the model.
    drive(1, 4'b0000, 0, 0, 0, 0, 4'b0000); cycle_end();
    for (int n = 0; n < 3000; n++) begin
      bit ei, ee;
      int s;
      bit [3:0] tog;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 99) == 0), irq_src ^ tog, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 4'($urandom));
      model_comb(ei, ee, s);
      check_outs($sformatf("rnd[%0d]", n), ei, ee, m_cause, m_pend, m_mask, (m_mode == 1));
      cycle_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Interrupt/exception sequencer for the single-cycle MIPS core. Latches peripheral interrupt requests, applies a software mask, and chooses the trap source. It drives the `Interrupt` and `Exception` inputs of the control decoder only when the core is in user mode (`pchigh`=0), then blocks further traps until the handler returns. It sits between the peripheral bus / instruction decoder and the control unit, and exports the cause code to the kernel.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, legal range 1..4. Source 0 has the highest priority.

Ports:
- `clk` in 1: the single system clock.
- `reset` in 1: synchronous, active-high.
- `irq_src` in NUM_SRC: peripheral request levels, synchronous to `clk`. A rising edge requests an interrupt.
- `pchigh` in 1: PC[31], the kernel-mode bit. No trap is issued while it is 1.
- `illegal_op` in 1: the current instruction is undefined. Combinational from the decoder.
- `eret` in 1: the current instruction is the handler return. Only meaningful in SERVICE.
- `mask_wr` in 1: write strobe for the mask register.
- `mask_wdata` in NUM_SRC: new mask value. A 1 enables that source.
- `Interrupt` out 1: take an interrupt this cycle. Goes to the control unit.
- `Exception` out 1: take an exception this cycle. Goes to the control unit.
- `cause` out 3: cause of the last taken trap. 0 means illegal instruction; 4+i means interrupt source i.
- `pending` out NUM_SRC: latched requests.
- `mask` out NUM_SRC: current mask.
- `in_service` out 1: high while the FSM is in SERVICE.

## Operation
- **Edge latch.** `irq_prev` is a register holding `irq_src`. For source i, `irq_src[i] & ~irq_prev[i]` sets `pending[i]`. Masked sources still latch. `pending[i]` clears on the edge where source i is taken. If a new edge arrives in the same cycle as the clear, set wins and the bit stays 1.
- **Mask.** On `mask_wr`, `mask <= mask_wdata` at the clock edge. The new value affects `Interrupt` from the next cycle.
- **Eligible set.** `elig = pending & mask`. The selected source is the lowest index set in `elig`.
- **FSM states.** IDLE, SERVICE, HOLDOFF.
- **Exception** is combinational: `Exception = illegal_op & ~pchigh & (state != SERVICE) & ~reset`.
- **Interrupt** is combinational: `Interrupt = (state == IDLE) & ~pchigh & |elig & ~illegal_op & ~reset`. Exception has priority; a blocked interrupt stays pending.
- **Transitions.**
  - IDLE → SERVICE on `Exception | Interrupt`.
  - SERVICE → HOLDOFF on `eret`.
  - HOLDOFF → SERVICE on `Exception`; otherwise HOLDOFF → IDLE.
- HOLDOFF lasts exactly one cycle. It guarantees that the instruction at the return address executes before the next interrupt is taken.
- **Cause update.** On entry to SERVICE, `cause` ← 0 for an exception, or 4+sel for an interrupt. Cause holds until the next trap.
- `eret` in IDLE or HOLDOFF: ignored.
- `illegal_op` or irq edges in SERVICE: no trap is issued. Edges are still latched into `pending`.
- `pchigh`=1 in IDLE: no trap; requests accumulate. When `pchigh` falls, a trap is issued the same cycle if eligible.

## Timing
- **Reset values.** state IDLE, `pending`=0, `irq_prev`=0, `mask`=0, `cause`=0, `in_service`=0. `Interrupt` and `Exception` are forced to 0 during `reset`.
- **Reset mid-service.** Reset returns the FSM to IDLE in one cycle and discards all pending requests.
- **Interrupt latency.** An edge sampled at edge k sets `pending` at k+1. `Interrupt` is high during cycle k+1, provided the FSM is IDLE, the source is unmasked, and `pchigh`=0.
- **Exception latency.** 0 cycles; same cycle as `illegal_op`.
- **Pulse width.** `Interrupt` and `Exception` are high for exactly one cycle per trap, because the FSM leaves IDLE at the next edge.
- `in_service` is registered and rises the cycle after the trap.

## Structure
- **Package `trap_pkg`:** `trap_state_t` (IDLE, SERVICE, HOLDOFF); cause constants `CAUSE_ILLEGAL`=3'd0 and `CAUSE_IRQ_BASE`=3'd4; `MAX_SRC`=4.
- **Sub-module `irq_edge_latch`:** one per source, generated NUM_SRC times. Holds `irq_prev` and `pending`, implements set-over-clear, and takes `clr` from the top.
- **Top `trap_controller`:** priority select, FSM, mask, and cause registers.

## Test plan
- Reset, `mask`=4'b1111, `irq_src[2]` 0→1 → `pending`=4'b0100 the next cycle. `Interrupt`=1 for one cycle. `cause`=6. `in_service`=1. `pending[2]` clears.
- Sources 1 and 3 rise in the same cycle, both unmasked → source 1 is taken first with `cause`=5. After `eret` → one HOLDOFF cycle with `Interrupt`=0, then source 3 is taken with `cause`=7.
- `illegal_op`=1 in the same cycle as eligible `pending[0]` → `Exception`=1, `Interrupt`=0, `cause`=0. `pending[0]` stays 1 and is taken one cycle after the eret + HOLDOFF sequence.
- `mask`=0 and `irq_src[0]` rises → `pending`=1 and no `Interrupt`. Write `mask`=1 → `Interrupt`=1 the following cycle.
- `pchigh`=1 with `pending`=4'b0010 and `illegal_op`=1 → no trap. Drop `pchigh` → `Exception`=1 immediately.
- Assert `reset` for one cycle while in SERVICE with `pending`=4'b1000 → the next cycle shows IDLE, `pending`=0, `mask`=0, `cause`=0, and `eret` has no effect.
